ram_arbiter: RTL and testbench

- Two-requester controller that shares the single-port parity RAM (16-bit x 1024, registered address and output stages) between requesters M0 and M1.
- Arbitrates round-robin and sequences the RAM control strobes: blk_select, wr_en, rd_en, addr_en, dout_en.
- Returns read data, with its parity bit, to the winning requester.
- Sits between the bus-side masters and the RAM instance.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_arbiter_rr_arb2.sv | 19 +
 rtl/ram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int MEM_WIDTH_DEF = 16;
  localparam int ADDR_SIZE_DEF = 10;
  localparam int RD_LAT_DEF    = 2;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the one not served last wins.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  always_comb begin
    winner = M0;
    if (req == 2'b10) begin
      winner = M1;
    end else if (req == 2'b11) begin
      winner = ~last;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port parity RAM between M0 and M1 with round-robin arbitration.
// Optional parity check on read capture is enabled by defining RAM_ARB_PARITY_CHK_EN.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int MEM_WIDTH = MEM_WIDTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int RD_LAT    = RD_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [ADDR_SIZE-1:0] m0_addr,
  input  logic [MEM_WIDTH-1:0] m0_wdata,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [MEM_WIDTH-1:0] m0_rdata,
  output logic                 m0_rparity,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [ADDR_SIZE-1:0] m1_addr,
  input  logic [MEM_WIDTH-1:0] m1_wdata,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [MEM_WIDTH-1:0] m1_rdata,
  output logic                 m1_rparity,
  output logic                 ram_blk_select,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic                 ram_addr_en,
  output logic                 ram_dout_en,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0] ram_din,
  input  logic [MEM_WIDTH-1:0] ram_dout,
`ifdef RAM_ARB_PARITY_CHK_EN
  output logic                 par_err,
`endif
  input  logic                 ram_parity
);

  state_e               state_q;
  logic                 last_q;
  logic [2:0]           cnt_q;
  logic                 cmd_we_q;
  logic                 cmd_id_q;
  logic [1:0]           gnt_q;
  logic [1:0]           rvalid_q;
  logic [1:0]           rparity_q;
  logic [MEM_WIDTH-1:0] rdata_q [2];
  logic                 blk_q, wr_q, rd_q, aen_q, den_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [MEM_WIDTH-1:0] din_q;
`ifdef RAM_ARB_PARITY_CHK_EN
  logic                 par_err_q;
`endif

  logic                 win_d;
  logic                 win_we_d;
  logic [ADDR_SIZE-1:0] win_addr_d;
  logic [MEM_WIDTH-1:0] win_wdata_d;

  rr_arb2 u_rr (
    .req    ({m1_req, m0_req}),
    .last   (last_q),
    .winner (win_d)
  );

  assign win_we_d    = (win_d == M1) ? m1_we    : m0_we;
  assign win_addr_d  = (win_d == M1) ? m1_addr  : m0_addr;
  assign win_wdata_d = (win_d == M1) ? m1_wdata : m0_wdata;

  // Reset pointer says M1 was served last, so a post-reset tie goes to M0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= M1;
      cnt_q      <= '0;
      cmd_we_q   <= 1'b0;
      cmd_id_q   <= M0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rparity_q  <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      blk_q      <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      aen_q      <= 1'b0;
      den_q      <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
`ifdef RAM_ARB_PARITY_CHK_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      aen_q    <= 1'b1;
      den_q    <= 1'b1;
      gnt_q    <= '0;
      rvalid_q <= '0;
`ifdef RAM_ARB_PARITY_CHK_EN
      par_err_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            cmd_id_q       <= win_d;
            cmd_we_q       <= win_we_d;
            addr_q         <= win_addr_d;
            din_q          <= win_wdata_d;
            gnt_q[win_d]   <= 1'b1;
            blk_q          <= 1'b1;
            wr_q           <= win_we_d;
            rd_q           <= ~win_we_d;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          blk_q  <= 1'b0;
          wr_q   <= 1'b0;
          rd_q   <= 1'b0;
          last_q <= cmd_id_q;
          if (cmd_we_q) begin
            state_q <= IDLE;
          end else begin
            cnt_q   <= 3'(RD_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 3'd0) begin
            rdata_q[cmd_id_q]   <= ram_dout;
            rparity_q[cmd_id_q] <= ram_parity;
            rvalid_q[cmd_id_q]  <= 1'b1;
`ifdef RAM_ARB_PARITY_CHK_EN
            par_err_q           <= (ram_parity != ^ram_dout);
`endif
            state_q             <= IDLE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_gnt         = gnt_q[0];
  assign m1_gnt         = gnt_q[1];
  assign m0_rvalid      = rvalid_q[0];
  assign m1_rvalid      = rvalid_q[1];
  assign m0_rdata       = rdata_q[0];
  assign m1_rdata       = rdata_q[1];
  assign m0_rparity     = rparity_q[0];
  assign m1_rparity     = rparity_q[1];
  assign ram_blk_select = blk_q;
  assign ram_wr_en      = wr_q;
  assign ram_rd_en      = rd_q;
  assign ram_addr_en    = aen_q;
  assign ram_dout_en    = den_q;
  assign ram_addr       = addr_q;
  assign ram_din        = din_q;
`ifdef RAM_ARB_PARITY_CHK_EN
  assign par_err        = par_err_q;
`endif

  // A requester must hold req until its grant pulse.
  a_m0_hold: assert property (@(posedge clk) disable iff (!rst)
    (m0_req && !m0_gnt) |=> (m0_req || m0_gnt));
  a_m1_hold: assert property (@(posedge clk) disable iff (!rst)
    (m1_req && !m1_gnt) |=> (m1_req || m1_gnt));
  a_wr_rd_excl: assert property (@(posedge clk) disable iff (!rst)
    !(ram_wr_en && ram_rd_en));

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter with a behavioural RAM and reference memory.
module tb_ram_arbiter;
  localparam int RD_LAT = 2;

  typedef struct packed {
    logic        we;
    logic [9:0]  addr;
    logic [15:0] data;
  } tx_t;

  typedef struct packed {
    logic [15:0] data;
    logic        par;
    logic        perr;
    logic [31:0] due;
  } exp_t;

  logic clk, rst;
  logic m0_req, m0_we, m1_req, m1_we;
  logic [9:0] m0_addr, m1_addr, ram_addr;
  logic [15:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_din, ram_dout;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rparity, m1_rparity;
  logic ram_blk_select, ram_wr_en, ram_rd_en, ram_addr_en, ram_dout_en, ram_parity;
`ifdef RAM_ARB_PARITY_CHK_EN
  logic par_err;
`endif

  ram_arbiter #(.MEM_WIDTH(16), .ADDR_SIZE(10), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rparity(m0_rparity),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rparity(m1_rparity),
    .ram_blk_select(ram_blk_select), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_addr_en(ram_addr_en), .ram_dout_en(ram_dout_en), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout),
`ifdef RAM_ARB_PARITY_CHK_EN
    .par_err(par_err),
`endif
    .ram_parity(ram_parity)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;
  tx_t  pend [2][$];
  exp_t exp_q [2][$];
  tx_t  cur [2];
  logic [1:0] cur_v = '0;
  logic hold_req0 = 1'b0;
  int   gap_pct = 0;
  logic contend = 1'b0;
  logic force_en = 1'b0, force_val = 1'b0;
  logic [15:0] refmem [1024];
  logic [15:0] last_rd [2];
  logic last_m, have_prev;
  int   last_gnt_cyc;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_chk++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req_v, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: registered address, registered output (two-cycle read).
  logic [15:0] mem [1024];
  logic        mpar [1024];
  logic [9:0]  a_q;
  logic [15:0] dout_q;
  logic        par_q;
  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; mpar[i] = 1'b0; end
    a_q = '0; dout_q = '0; par_q = 1'b0;
    forever begin
      @(posedge clk);
      if (ram_addr_en && ram_blk_select) begin
        a_q <= ram_addr;
        if (ram_wr_en) begin mem[ram_addr] <= ram_din; mpar[ram_addr] <= ^ram_din; end
      end
      if (ram_dout_en) begin dout_q <= mem[a_q]; par_q <= mpar[a_q]; end
    end
  end
  assign ram_dout   = dout_q;
  assign ram_parity = force_en ? force_val : par_q;

  // Driver: presents queued transactions, holds each until its grant.
  initial begin
    logic [1:0] gv;
    cur[0] = '0; cur[1] = '0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    forever begin
      @(negedge clk);
      gv = {m1_gnt, m0_gnt};
      for (int m = 0; m < 2; m++) begin
        if (cur_v[m] && gv[m]) cur_v[m] = 1'b0;
        if (!cur_v[m] && pend[m].size() > 0 && $urandom_range(99) >= gap_pct) begin
          cur[m] = pend[m].pop_front();
          cur_v[m] = 1'b1;
        end
      end
      m0_req = cur_v[0] | hold_req0; m0_we = cur[0].we; m0_addr = cur[0].addr; m0_wdata = cur[0].data;
      m1_req = cur_v[1];             m1_we = cur[1].we; m1_addr = cur[1].addr; m1_wdata = cur[1].data;
    end
  end

  // Monitor / scoreboard.
  logic any_out;
  assign any_out = |{m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_rparity,
                     m1_rparity, ram_blk_select, ram_wr_en, ram_rd_en, ram_addr_en,
                     ram_dout_en, ram_addr, ram_din
`ifdef RAM_ARB_PARITY_CHK_EN
                     , par_err
`endif
                     };

  initial begin
    logic [1:0] req_s, gv, rv;
    logic g, exp_w;
    tx_t t;
    exp_t e;
    for (int i = 0; i < 1024; i++) refmem[i] = '0;
    last_rd[0] = '0; last_rd[1] = '0; last_m = 1'b1; have_prev = 1'b0; last_gnt_cyc = 0;
    forever begin
      @(posedge clk);
      req_s = {m1_req, m0_req};
      #1;
      cyc++;
      if (!rst) begin
        check("reset_outputs", 32'(any_out), 32'd0);
        exp_q[0].delete(); exp_q[1].delete();
        last_rd[0] = '0; last_rd[1] = '0; last_m = 1'b1; have_prev = 1'b0;
      end else begin
        check("ram_enables", 32'({ram_addr_en, ram_dout_en}), 32'd3);
        gv = {m1_gnt, m0_gnt};
        if (gv != 2'b00) begin
          g = gv[1];
          exp_w = (req_s == 2'b11) ? ~last_m : req_s[1];
          check("gnt_winner", 32'({req_s != 2'b00, gv}), 32'({1'b1, exp_w ? 2'b10 : 2'b01}));
          last_m = g;
          t = cur[g];
          check("issue_strobes", 32'({ram_blk_select, ram_wr_en, ram_rd_en}), 32'({1'b1, t.we, ~t.we}));
          check("issue_addr", 32'(ram_addr), 32'(t.addr));
          if (t.we) begin
            check("issue_din", 32'(ram_din), 32'(t.data));
            refmem[t.addr] = t.data;
          end else begin
            e.data = refmem[t.addr];
            e.par  = force_en ? force_val : ^refmem[t.addr];
            e.perr = (e.par != ^e.data);
            e.due  = 32'(cyc + RD_LAT + 1);
            exp_q[g].push_back(e);
          end
          if (contend && have_prev && req_s == 2'b11) check("gnt_spacing", 32'(cyc - last_gnt_cyc), 32'd2);
          have_prev = contend;
          last_gnt_cyc = cyc;
        end else begin
          check("idle_strobes", 32'({ram_blk_select, ram_wr_en, ram_rd_en}), 32'd0);
        end
        rv = {m1_rvalid, m0_rvalid};
        for (int m = 0; m < 2; m++) begin
          if (rv[m]) begin
            if (exp_q[m].size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL rvalid_unexpected: m%0d rvalid got 1, required 0 (cycle %0d)", m, cyc);
            end else begin
              e = exp_q[m].pop_front();
              check("rd_latency", 32'(cyc), e.due);
              check("rparity", 32'(m ? m1_rparity : m0_rparity), 32'(e.par));
`ifdef RAM_ARB_PARITY_CHK_EN
              check("par_err", 32'(par_err), 32'(e.perr));
`endif
              last_rd[m] = e.data;
            end
          end else if (exp_q[m].size() > 0 && cyc > int'(exp_q[m][0].due)) begin
            e = exp_q[m].pop_front();
            n_chk++; n_fail++;
            $display("FAIL rvalid_missing: m%0d rvalid got 0, required 1 at cycle %0d", m, e.due);
          end
        end
`ifdef RAM_ARB_PARITY_CHK_EN
        if (rv == 2'b00 && par_err) begin
          n_chk++; n_fail++;
          $display("FAIL par_err_stray: got 1, required 0 (cycle %0d)", cyc);
        end
`endif
        check("rdata", {m1_rdata, m0_rdata}, {last_rd[1], last_rd[0]});
      end
    end
  end

  task automatic push_tx(input int m, input logic we, input logic [9:0] a, input logic [15:0] d);
    tx_t t;
    t.we = we; t.addr = a; t.data = d;
    pend[m].push_back(t);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (k < budget && (pend[0].size() + pend[1].size() + exp_q[0].size() + exp_q[1].size() != 0 || cur_v != 2'b00)) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: traffic still pending after %0d cycles, required drained", budget);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k;
    rst = 1'b0;
    hold_req0 = 1'b1;
    repeat (5) @(negedge clk);
    hold_req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    push_tx(0, 1'b1, 10'h005, 16'hA5A5);
    wait_done(50);
    push_tx(1, 1'b0, 10'h005, 16'h0000);
    wait_done(50);

    push_tx(1, 1'b0, 10'h005, 16'h0000);
    k = 0;
    while (k < 50 && !m1_gnt) begin @(negedge clk); k++; end
    if (k >= 50) begin n_chk++; n_fail++; $display("FAIL timeout: m1_gnt got 0, required 1"); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    push_tx(1, 1'b0, 10'h005, 16'h0000);
    wait_done(50);

    push_tx(0, 1'b1, 10'h3FF, 16'h1234);
    push_tx(1, 1'b0, 10'h3FF, 16'h0000);
    wait_done(50);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    contend = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_tx(0, 1'b1, 10'(i), 16'($urandom));
      push_tx(1, 1'b1, 10'(i + 8), 16'($urandom));
    end
    wait_done(200);
    contend = 1'b0;

    gap_pct = 30;
    for (int i = 0; i < 40; i++) begin
      for (int m = 0; m < 2; m++) begin
        push_tx(m, 1'($urandom_range(1)),
                ($urandom_range(9) == 0) ? 10'h3FF : 10'($urandom_range(15)), 16'($urandom));
      end
    end
    wait_done(4000);
    gap_pct = 0;

    push_tx(0, 1'b1, 10'h020, 16'h0003);
    push_tx(0, 1'b1, 10'h021, 16'h0001);
    wait_done(50);
    force_en = 1'b1; force_val = 1'b1;
    push_tx(0, 1'b0, 10'h020, 16'h0000);
    push_tx(1, 1'b0, 10'h021, 16'h0000);
    wait_done(100);
    force_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
